// File: rtl/lane_demux_pkg.sv
// Shared symbol constants and enums for the lane demux.
package lane_demux_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_COM = 8'hBC;

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  typedef enum logic [2:0] {
    SYM_NONE,
    SYM_START,
    SYM_END,
    SYM_EDB,
    SYM_OS
  } sym_class_t;

endpackage

// File: rtl/k_symbol_decode.sv
// Combinational control-symbol classifier for the lane demux.
module k_symbol_decode
  import lane_demux_pkg::*;
(
  input  logic [7:0]  data,
  output logic        recognised,
  output sym_class_t  sym_class
);

  // Map a byte onto its framing / ordered-set class
  always_comb begin
    sym_class = SYM_NONE;
    case (data)
      K_STP, K_SDP:                 sym_class = SYM_START;
      K_END:                        sym_class = SYM_END;
      K_EDB:                        sym_class = SYM_EDB;
      K_SKP, K_IDL, K_FTS, K_COM:   sym_class = SYM_OS;
      default:                      sym_class = SYM_NONE;
    endcase
    recognised = (sym_class != SYM_NONE);
  end

endmodule

// File: rtl/lane_demux.sv
// Byte-to-word lane demux with PCIe framing tracking.
// Optional saturating protocol-error counter: define LANE_DEMUX_ERR_CNT_EN.
//
// state | meaning
// IDLE  | outside a packet; data bytes are dropped as errors
// PKT   | inside a packet; data bytes are packed into lanes
module lane_demux
  import lane_demux_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 valid_in,
  input  logic [7:0]           data_in,
  output logic                 in_ready,
  output logic [8*LANES-1:0]   data_out,
  output logic [LANES-1:0]     byte_en,
  output logic                 sop,
  output logic                 eop,
  output logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           ctrl_out,
  output logic                 ctrl_valid
`ifdef LANE_DEMUX_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]     err_count
`endif
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [LANES-1:0][7:0]   acc_q;
  logic [LANES-1:0][7:0]   word_next;
  logic [LANES-1:0]        be_partial;
  logic                    sop_pending_q;

  logic                    sym_hit;
  sym_class_t              sym_class;

  logic                    wr_byte;
  logic                    emit;
  logic                    emit_full;
  logic                    emit_eop;
  logic                    emit_abort;
  logic                    start_pkt;
  logic                    ctrl_hit;
  logic                    proto_err;

  assign in_ready = !out_valid || out_ready;

  k_symbol_decode u_dec (
    .data       (data_in),
    .recognised (sym_hit),
    .sym_class  (sym_class)
  );

  // Framing state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-byte actions; nothing happens unless the byte is taken
  always_comb begin
    state_d    = state_q;
    wr_byte    = 1'b0;
    emit       = 1'b0;
    emit_full  = 1'b0;
    emit_eop   = 1'b0;
    emit_abort = 1'b0;
    start_pkt  = 1'b0;
    ctrl_hit   = 1'b0;
    proto_err  = 1'b0;
    if (in_ready) begin
      if (valid_in) begin
        if (state_q == PKT) begin
          wr_byte = 1'b1;
          if (idx_q == LAST_IDX) begin
            emit      = 1'b1;
            emit_full = 1'b1;
          end
        end else begin
          proto_err = 1'b1;
        end
      end else begin
        ctrl_hit = sym_hit;
        case (sym_class)
          SYM_START: begin
            // a restart closes any open packet as aborted
            if (state_q == PKT) begin
              emit       = 1'b1;
              emit_eop   = 1'b1;
              emit_abort = 1'b1;
              proto_err  = 1'b1;
            end
            start_pkt = 1'b1;
            state_d   = PKT;
          end
          SYM_END, SYM_EDB: begin
            if (state_q == PKT) begin
              emit       = 1'b1;
              emit_eop   = 1'b1;
              emit_abort = (sym_class == SYM_EDB);
              state_d    = IDLE;
            end else begin
              proto_err = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Word as it will leave: accumulator plus the byte landing this cycle
  always_comb begin
    word_next = acc_q;
    if (wr_byte) word_next[idx_q] = data_in;
  end

  // Contiguous lane mask covering the lanes filled so far
  always_comb begin
    be_partial = '0;
    for (int k = 0; k < LANES; k++) be_partial[k] = (k < int'(idx_q));
  end

  // Lane accumulator; cleared on start and after every emitted word so unused lanes read zero
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      acc_q         <= '0;
      idx_q         <= '0;
      sop_pending_q <= 1'b0;
    end else begin
      if (start_pkt || emit) begin
        acc_q <= '0;
        idx_q <= '0;
      end else if (wr_byte) begin
        acc_q[idx_q] <= data_in;
        idx_q        <= idx_q + 1'b1;
      end
      if (start_pkt)  sop_pending_q <= 1'b1;
      else if (emit)  sop_pending_q <= 1'b0;
    end
  end

  // Output word register with valid/ready hold
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      byte_en   <= '0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      abort     <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      data_out  <= word_next;
      byte_en   <= emit_full ? {LANES{1'b1}} : be_partial;
      sop       <= sop_pending_q;
      eop       <= emit_eop;
      abort     <= emit_abort;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Last recognised control symbol and its one-cycle strobe
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ctrl_out   <= '0;
      ctrl_valid <= 1'b0;
    end else begin
      ctrl_valid <= ctrl_hit;
      if (ctrl_hit) ctrl_out <= data_in;
    end
  end

`ifdef LANE_DEMUX_ERR_CNT_EN
  // Saturating count of framing violations
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                            err_count <= '0;
    else if (proto_err && (err_count != '1)) err_count <= err_count + 1'b1;
  end
`else
  logic [CNT_W-1:0] err_unused;
  assign err_unused = CNT_W'(proto_err);
`endif

endmodule

// File: tb/tb_lane_demux.sv
// Self-checking bench for lane_demux: queue-based reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_lane_demux;
  import lane_demux_pkg::*;

  localparam int LANES = 4;
  localparam int CNT_W = 16;
  localparam int DW    = 8 * LANES;

  logic             clk = 1'b0;
  logic             reset_L;
  logic             valid_in;
  logic [7:0]       data_in;
  logic             in_ready;
  logic [DW-1:0]    data_out;
  logic [LANES-1:0] byte_en;
  logic             sop, eop, abort, out_valid, out_ready;
  logic [7:0]       ctrl_out;
  logic             ctrl_valid;
`ifdef LANE_DEMUX_ERR_CNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  always #5 clk = ~clk;

  lane_demux #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .byte_en    (byte_en),
    .sop        (sop),
    .eop        (eop),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ctrl_out   (ctrl_out),
    .ctrl_valid (ctrl_valid)
`ifdef LANE_DEMUX_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit               m_ov, m_sop, m_eop, m_abort, m_cv, m_in_pkt, m_sopp;
  logic [7:0]       m_co;
  logic [LANES-1:0] m_be;
  logic [DW-1:0]    m_data;
  logic [7:0]       mq[$];
  int unsigned      m_err;

  task automatic m_reset();
    m_ov = 0; m_sop = 0; m_eop = 0; m_abort = 0; m_cv = 0;
    m_in_pkt = 0; m_sopp = 0; m_co = '0; m_be = '0; m_data = '0;
    mq.delete(); m_err = 0;
  endtask

  task automatic m_bump();
    if (m_err < (2 ** CNT_W) - 1) m_err++;
  endtask

  task automatic m_emit(input bit e, input bit a);
    m_data = '0;
    m_be   = '0;
    foreach (mq[i]) begin
      m_data[8*i +: 8] = mq[i];
      m_be[i] = 1'b1;
    end
    m_sop = m_sopp; m_eop = e; m_abort = a;
    m_sopp = 0;
    mq.delete();
  endtask

  task automatic m_step();
    bit take, load;
    take = !m_ov || out_ready;
    load = 0;
    m_cv = 0;
    if (take) begin
      if (valid_in) begin
        if (m_in_pkt) begin
          mq.push_back(data_in);
          if (mq.size() == LANES) begin m_emit(0, 0); load = 1; end
        end else m_bump();
      end else if (data_in inside {K_STP, K_SDP}) begin
        m_cv = 1; m_co = data_in;
        if (m_in_pkt) begin m_emit(1, 1); load = 1; m_bump(); end
        m_in_pkt = 1; mq.delete(); m_sopp = 1;
      end else if (data_in inside {K_END, K_EDB}) begin
        m_cv = 1; m_co = data_in;
        if (m_in_pkt) begin m_emit(1, data_in == K_EDB); load = 1; m_in_pkt = 0; end
        else m_bump();
      end else if (data_in inside {K_SKP, K_IDL, K_FTS, K_COM}) begin
        m_cv = 1; m_co = data_in;
      end
    end
    if (load) m_ov = 1;
    else if (out_ready) m_ov = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_L);
      if (!reset_L) m_reset();
      else m_step();
    end
  end

  // ---------------- compare + logging ----------------
  typedef struct {
    logic [DW-1:0]    d;
    logic [LANES-1:0] be;
    logic             s, e, a;
  } wrec_t;
  wrec_t      wlog[$];
  logic [7:0] clog[$];

  initial begin
    logic [DW-1:0] mask;
    wrec_t w;
    forever begin
      @(negedge clk);
      #2;
      if (reset_L) begin
        chk("out_valid", out_valid, m_ov);
        chk("in_ready", in_ready, !m_ov || out_ready);
        chk("ctrl_valid", ctrl_valid, m_cv);
        chk("ctrl_out", ctrl_out, m_co);
        if (m_ov) begin
          mask = '0;
          for (int k = 0; k < LANES; k++) if (m_be[k]) mask[8*k +: 8] = 8'hFF;
          chk("byte_en", byte_en, m_be);
          chk("sop", sop, m_sop);
          chk("eop", eop, m_eop);
          chk("abort", abort, m_abort);
          chk("data_out", data_out & mask, m_data & mask);
        end
`ifdef LANE_DEMUX_ERR_CNT_EN
        chk("err_count", err_count, m_err[CNT_W-1:0]);
`endif
        if (out_valid && out_ready) begin
          w.d = data_out; w.be = byte_en; w.s = sop; w.e = eop; w.a = abort;
          wlog.push_back(w);
        end
        if (ctrl_valid) clog.push_back(ctrl_out);
      end
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic v, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    valid_in = v; data_in = d;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready stuck at %0b for byte %0h", in_ready, d);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0; data_in = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_L = 1'b0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    wlog.delete(); clog.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset_L = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_byte_en", byte_en, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_ctrl_out", ctrl_out, 0);
    chk("rst_ctrl_valid", ctrl_valid, 0);
    @(negedge clk); reset_L = 1'b1;

    // full word then empty terminating word
    wlog.delete(); clog.delete();
    send(0, K_STP); send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44); send(0, K_END);
    idle(3);
    chk("t1_nwords", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("t1_w0_data", wlog[0].d, 32'h44332211);
      chk("t1_w0_be", wlog[0].be, 4'hF);
      chk("t1_w0_flags", {wlog[0].s, wlog[0].e, wlog[0].a}, 3'b100);
      chk("t1_w1_be", wlog[1].be, 4'h0);
      chk("t1_w1_flags", {wlog[1].s, wlog[1].e, wlog[1].a}, 3'b010);
    end
    chk("t1_nctrl", clog.size(), 2);
    if (clog.size() >= 2) begin
      chk("t1_ctrl0", clog[0], 8'hFB);
      chk("t1_ctrl1", clog[1], 8'hFD);
    end

    // EDB abort, then data in IDLE produces nothing
    wlog.delete(); clog.delete();
    send(0, K_STP); send(1, 8'hA1); send(1, 8'hA2); send(0, K_EDB);
    idle(3);
    send(1, 8'h77);
    idle(3);
    chk("t2_nwords", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      chk("t2_data", wlog[0].d[15:0], 16'hA2A1);
      chk("t2_be", wlog[0].be, 4'h3);
      chk("t2_flags", {wlog[0].s, wlog[0].e, wlog[0].a}, 3'b111);
    end

    // backpressure
    wlog.delete(); clog.delete();
    ready_mode = 0;
    send(0, K_SDP); send(1, 8'hB1); send(1, 8'hB2); send(1, 8'hB3); send(1, 8'hB4);
    idle(3);
    chk("t3_held_valid", out_valid, 1);
    chk("t3_held_in_ready", in_ready, 0);
    chk("t3_held_data", data_out, 32'hB4B3B2B1);
    fork
      begin send(1, 8'hB5); send(1, 8'hB6); send(0, K_END); end
      begin repeat (4) @(posedge clk); ready_mode = 1; end
    join
    idle(3);
    chk("t3_nwords", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("t3_w0_data", wlog[0].d, 32'hB4B3B2B1);
      chk("t3_w0_sop", wlog[0].s, 1);
      chk("t3_w1_data", wlog[1].d[15:0], 16'hB6B5);
      chk("t3_w1_be", wlog[1].be, 4'h3);
      chk("t3_w1_flags", {wlog[1].s, wlog[1].e, wlog[1].a}, 3'b010);
    end

    // ordered sets inside a packet
    wlog.delete(); clog.delete();
    send(0, K_STP); send(1, 8'h01); send(0, K_SKP); send(1, 8'h02); send(0, K_COM);
    send(1, 8'h03); send(1, 8'h04); send(0, K_END);
    idle(3);
    chk("t4_nctrl", clog.size(), 4);
    if (clog.size() >= 4) begin
      chk("t4_ctrl1", clog[1], 8'h1C);
      chk("t4_ctrl2", clog[2], 8'hBC);
    end
    chk("t4_nwords", wlog.size(), 2);
    if (wlog.size() >= 1) chk("t4_w0_data", wlog[0].d, 32'h04030201);

    // errors and restart
    do_reset();
    send(1, 8'h55); send(0, K_STP); send(1, 8'h01); send(0, K_STP); send(1, 8'h02); send(0, K_END);
    idle(3);
    chk("t5_nwords", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("t5_w0_data", wlog[0].d[7:0], 8'h01);
      chk("t5_w0_be", wlog[0].be, 4'h1);
      chk("t5_w0_flags", {wlog[0].s, wlog[0].e, wlog[0].a}, 3'b111);
      chk("t5_w1_data", wlog[1].d[7:0], 8'h02);
      chk("t5_w1_be", wlog[1].be, 4'h1);
      chk("t5_w1_flags", {wlog[1].s, wlog[1].e, wlog[1].a}, 3'b110);
    end
`ifdef LANE_DEMUX_ERR_CNT_EN
    chk("t5_err_count", err_count, 2);
`endif

    // reset mid-packet
    send(0, K_STP); send(1, 8'hC1); send(1, 8'hC2); send(1, 8'hC3); send(1, 8'hC4);
    send(1, 8'hC5); send(1, 8'hC6);
    @(negedge clk); reset_L = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_data_out", data_out, 0);
    chk("t6_byte_en", byte_en, 0);
    chk("t6_flags", {sop, eop, abort}, 3'b000);
    chk("t6_ctrl", {ctrl_out, ctrl_valid}, 9'h0);
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    wlog.delete(); clog.delete();
    send(0, K_STP); send(1, 8'hD1); send(0, K_END);
    idle(3);
    chk("t6_nwords", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      chk("t6_data", wlog[0].d[7:0], 8'hD1);
      chk("t6_flags_after", {wlog[0].s, wlog[0].e, wlog[0].a}, 3'b110);
    end

    // random traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 12)       send(1, 8'($urandom));
      else if (r < 14)  send(0, ($urandom_range(0, 1) != 0) ? K_STP : K_SDP);
      else if (r < 16)  send(0, K_END);
      else if (r < 17)  send(0, K_EDB);
      else if (r < 19) begin
        case ($urandom_range(0, 3))
          0:       send(0, K_SKP);
          1:       send(0, K_IDL);
          2:       send(0, K_FTS);
          default: send(0, K_COM);
        endcase
      end else        send(0, 8'($urandom));
    end
    idle(5);
    ready_mode = 1;
    idle(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lane_demux.md
Name: lane_demux

Overview:
- Parametrised successor to the single-byte control/data demux.
- Classifies each incoming byte as a data byte or a PCIe framing/ordered-set control symbol, and tracks packet framing (STP/SDP ... END/EDB) with an FSM.
- Packs in-packet data bytes into LANES-wide words with byte enables, behind a valid/ready handshake.
- Sits between the byte-serial receive path and the multi-lane packet consumer.

Parameters:
- LANES, 4: bytes per output word; 2..16.
- CNT_W, 16: width of the error counter (optional feature only).

Ports:
- clk  in  1  clock; all logic on posedge only.
- reset_L  in  1  asynchronous, active-low reset.
- valid_in  in  1  1 = data_in is a data byte; 0 = data_in is a control-symbol candidate.
- data_in  in  8  input byte.
- in_ready  out  1  input accepted this cycle when high.
- data_out  out  8*LANES  packed word; byte k on bits [8k+7:8k].
- byte_en  out  LANES  per-lane valid mask, contiguous from lane 0.
- sop  out  1  word is the first of a packet.
- eop  out  1  word terminates a packet.
- abort  out  1  packet terminated by EDB or by a restart.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- ctrl_out  out  8  last recognised control symbol.
- ctrl_valid  out  1  one-cycle pulse when ctrl_out updates.
- err_count  out  CNT_W  protocol error count (only with ERR_CNT_EN).

Behaviour:
- Reset values (async, reset_L low): data_out=0, byte_en=0, sop=eop=abort=0, out_valid=0, ctrl_out=0, ctrl_valid=0, err_count=0, FSM=IDLE, accumulator index=0, sop_pending=0.
- A reset mid-packet discards the partial word; no eop is produced.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - A byte is consumed only when in_ready is high; otherwise the producer holds data_in and valid_in.
  - The output register holds data_out and its flags while out_valid & !out_ready.
  - out_valid clears on handshake unless a new word is loaded in the same cycle.
- Symbols: STP=FB, SDP=5C, END=FD, EDB=FE, SKP=1C, IDL=7C, FTS=3C, COM=BC.
  - A recognised symbol with valid_in=0 is accepted: ctrl_out<=symbol and ctrl_valid=1 for exactly one cycle.
  - valid_in=0 with an unrecognised byte is a no-op: no ctrl_valid, no state change.
- FSM states are IDLE and PKT.
- In IDLE:
  - A data byte is dropped and counts as an error.
  - STP or SDP: go to PKT, clear the accumulator, set sop_pending.
  - END or EDB: error; no output.
- In PKT, data bytes:
  - Each byte is written to lane idx, then idx++.
  - When the byte lands in lane LANES-1, the word is emitted the next cycle with byte_en all ones, sop=sop_pending, eop=0, abort=0. Then idx=0 and sop_pending is cleared.
- In PKT, END:
  - Emit the accumulated word with byte_en=(1<<idx)-1, eop=1, sop=sop_pending, abort=0.
  - idx=0 is legal: the word is emitted with byte_en=0 and eop=1.
  - Then go to IDLE.
- In PKT, EDB: same as END but abort=1.
- In PKT, STP or SDP:
  - Emit the partial word with eop=1 and abort=1, and count an error.
  - Then set sop_pending and stay in PKT.
- Ordered sets (SKP, IDL, FTS, COM) in any state: reported on ctrl_out only. Data, idx and state are unchanged.
- Latency: a word appears on out_valid one cycle after its final byte or terminating symbol is accepted.
- Only one input is accepted per cycle, so there are no simultaneous input events. An output handshake and a new load in the same cycle keep out_valid=1 with the new contents.

Optional Feature:
- Macro LANE_DEMUX_ERR_CNT_EN.
- Defined:
  - err_count increments on: data in IDLE, END/EDB in IDLE, STP/SDP in PKT.
  - It saturates at all ones.
- Undefined:
  - The err_count port is absent and no counter logic is built.
  - All other behaviour is identical.

Decomposition:
- Package lane_demux_pkg holds:
  - the 8 symbol constants;
  - the FSM state enum {IDLE, PKT};
  - a symbol-class enum {SYM_NONE, SYM_START, SYM_END, SYM_EDB, SYM_OS}.
- Sub-module k_symbol_decode (combinational): maps data_in to {recognised, class}. It is used by the FSM and by the ctrl_out logic.

Test Plan:
- Reset, then STP, data 11,22,33,44, END with LANES=4 and out_ready=1 -> word 44332211, byte_en=F, sop=1, eop=0. Then an empty word, byte_en=0, eop=1. ctrl_valid pulses for FB and FD.
- STP, data A1,A2, EDB -> one word byte_en=3, data low bytes A2A1, sop=1, eop=1, abort=1; FSM returns to IDLE.
- STP, 4 data bytes with out_ready=0 -> out_valid held; in_ready=0 until out_ready=1; no byte lost or duplicated.
- SKP, COM between data bytes inside a packet -> ctrl_out=1C then BC; word contents unaffected.
- Data in IDLE, STP, 01, STP, 02, END (with ERR_CNT_EN) -> err_count=2; abort word byte_en=1 data 01; then sop word byte_en=1 data 02 eop=1.
- reset_L low mid-packet after 2 bytes -> all outputs 0 immediately; the next STP starts cleanly with sop=1.
